// File: rtl/load_store_unit.sv
// MEM-stage load/store unit in front of a 16-bit word data_memory.
// Word and byte loads/stores; byte stores are read-modify-write of the containing word.
module load_store_unit #(
   parameter int ADDR_W = 16,
   parameter int DATA_W = 16,
   parameter int RD_LAT = 1
) (
   input  logic              clk,
   input  logic              reset,
   input  logic              req_valid,
   output logic              req_ready,
   input  logic [1:0]        req_op,
   input  logic [ADDR_W-1:0] req_addr,
   input  logic [DATA_W-1:0] req_wdata,
   input  logic [2:0]        req_rd,
   output logic              resp_valid,
   input  logic              resp_ready,
   output logic [DATA_W-1:0] resp_data,
   output logic [2:0]        resp_rd,
   output logic              resp_is_load,
   output logic              resp_misalign,
   output logic              mem_write_enable,
   output logic              mem_read_enable,
   output logic [ADDR_W-1:0] mem_addr,
   output logic [DATA_W-1:0] mem_data_in,
   input  logic [DATA_W-1:0] mem_read_data_out
);

   typedef enum logic [2:0] {
      IDLE     = 3'd0,
      ISSUE_RD = 3'd1,
      WAIT_RD  = 3'd2,
      ISSUE_WR = 3'd3,
      RESP     = 3'd4
   } state_t;

   localparam logic [1:0] OP_LW     = 2'b00;
   localparam logic [1:0] OP_SW     = 2'b01;
   localparam logic [1:0] OP_LB     = 2'b10;
   localparam logic [1:0] OP_SB     = 2'b11;
   localparam logic [1:0] LAST_WAIT = 2'(RD_LAT - 1);

   state_t            state_r;
   state_t            next_state_s;
   logic [1:0]        op_r;
   logic              byte_hi_r;
   logic [7:0]        wbyte_r;
   logic [2:0]        rd_r;
   logic [1:0]        wait_cnt_r;
   logic              accept_s;
   logic              misalign_s;

   logic              mem_read_enable_s;
   logic              mem_write_enable_s;
   logic [ADDR_W-1:0] mem_addr_s;
   logic [DATA_W-1:0] mem_data_in_s;
   logic              resp_valid_s;
   logic [DATA_W-1:0] resp_data_s;
   logic [2:0]        resp_rd_s;
   logic              resp_is_load_s;
   logic              resp_misalign_s;

   function automatic logic [15:0] merge_byte(input logic [15:0] word, input logic [7:0] b,
                                              input logic hi);
      logic [15:0] m;
      if (hi) m = {b, word[7:0]};
      else    m = {word[15:8], b};
      return m;
   endfunction

   function automatic logic [15:0] load_byte(input logic [15:0] word, input logic hi);
      logic [7:0] b;
      if (hi) b = word[15:8];
      else    b = word[7:0];
      return {{8{b[7]}}, b};
   endfunction

   assign req_ready  = (state_r == IDLE) && !reset;
   assign accept_s   = req_valid && req_ready;
   // Only word ops (LW/SW, op[1]=0) can fault on an odd address.
   assign misalign_s = !req_op[1] && req_addr[0];

   // State register
   always_ff @(posedge clk) begin
      if (reset) state_r <= IDLE;
      else       state_r <= next_state_s;
   end

   // Next-state logic
   always_comb begin
      next_state_s = state_r;
      case (state_r)
         IDLE: begin
            if (!accept_s)                next_state_s = IDLE;
            else if (misalign_s)          next_state_s = RESP;
            else if (req_op == OP_SW)     next_state_s = ISSUE_WR;
            else                          next_state_s = ISSUE_RD;
         end
         ISSUE_RD: next_state_s = WAIT_RD;
         WAIT_RD: begin
            if (wait_cnt_r != LAST_WAIT)  next_state_s = WAIT_RD;
            else if (op_r == OP_SB)       next_state_s = ISSUE_WR;
            else                          next_state_s = RESP;
         end
         ISSUE_WR: next_state_s = RESP;
         RESP: begin
            if (resp_ready) next_state_s = IDLE;
            else            next_state_s = RESP;
         end
         default: next_state_s = IDLE;
      endcase
   end

   // Next values of the registered memory and response outputs
   always_comb begin
      mem_read_enable_s  = (next_state_s == ISSUE_RD);
      mem_write_enable_s = (next_state_s == ISSUE_WR);
      mem_addr_s         = mem_addr;
      mem_data_in_s      = {DATA_W{1'b0}};
      resp_valid_s       = 1'b0;
      resp_data_s        = {DATA_W{1'b0}};
      resp_rd_s          = 3'd0;
      resp_is_load_s     = 1'b0;
      resp_misalign_s    = 1'b0;

      if (accept_s) mem_addr_s = {1'b0, req_addr[ADDR_W-1:1]};
      else          mem_addr_s = mem_addr;

      // A write entered from IDLE is a plain SW; otherwise it is the SB merge.
      if (next_state_s != ISSUE_WR)  mem_data_in_s = {DATA_W{1'b0}};
      else if (state_r == IDLE)      mem_data_in_s = req_wdata;
      else                           mem_data_in_s = merge_byte(mem_read_data_out, wbyte_r, byte_hi_r);

      case (state_r)
         IDLE: begin
            if (next_state_s == RESP) begin
               resp_valid_s    = 1'b1;
               resp_rd_s       = req_rd;
               resp_is_load_s  = !req_op[0];
               resp_misalign_s = 1'b1;
            end else begin
               resp_valid_s    = 1'b0;
            end
         end
         WAIT_RD: begin
            if (next_state_s == RESP) begin
               resp_valid_s   = 1'b1;
               resp_rd_s      = rd_r;
               resp_is_load_s = 1'b1;
               if (op_r == OP_LB) resp_data_s = load_byte(mem_read_data_out, byte_hi_r);
               else               resp_data_s = mem_read_data_out;
            end else begin
               resp_valid_s   = 1'b0;
            end
         end
         ISSUE_WR: begin
            resp_valid_s = 1'b1;
            resp_rd_s    = rd_r;
         end
         RESP: begin
            if (next_state_s == RESP) begin
               resp_valid_s    = resp_valid;
               resp_data_s     = resp_data;
               resp_rd_s       = resp_rd;
               resp_is_load_s  = resp_is_load;
               resp_misalign_s = resp_misalign;
            end else begin
               resp_valid_s    = 1'b0;
            end
         end
         default: resp_valid_s = 1'b0;
      endcase
   end

   // Request capture and read-latency counter
   always_ff @(posedge clk) begin
      if (reset) begin
         op_r       <= OP_LW;
         byte_hi_r  <= 1'b0;
         wbyte_r    <= 8'd0;
         rd_r       <= 3'd0;
         wait_cnt_r <= 2'd0;
      end else begin
         if (accept_s) begin
            op_r      <= req_op;
            byte_hi_r <= req_addr[0];
            wbyte_r   <= req_wdata[7:0];
            rd_r      <= req_rd;
         end
         if (state_r == WAIT_RD) wait_cnt_r <= wait_cnt_r + 2'd1;
         else                    wait_cnt_r <= 2'd0;
      end
   end

   // Output registers
   always_ff @(posedge clk) begin
      if (reset) begin
         mem_read_enable  <= 1'b0;
         mem_write_enable <= 1'b0;
         mem_addr         <= {ADDR_W{1'b0}};
         mem_data_in      <= {DATA_W{1'b0}};
         resp_valid       <= 1'b0;
         resp_data        <= {DATA_W{1'b0}};
         resp_rd          <= 3'd0;
         resp_is_load     <= 1'b0;
         resp_misalign    <= 1'b0;
      end else begin
         mem_read_enable  <= mem_read_enable_s;
         mem_write_enable <= mem_write_enable_s;
         mem_addr         <= mem_addr_s;
         mem_data_in      <= mem_data_in_s;
         resp_valid       <= resp_valid_s;
         resp_data        <= resp_data_s;
         resp_rd          <= resp_rd_s;
         resp_is_load     <= resp_is_load_s;
         resp_misalign    <= resp_misalign_s;
      end
   end

endmodule

// File: tb/tb_load_store_unit.sv
// Scoreboard bench for load_store_unit: directed ops against a word memory model,
// with responses and memory writes checked by a separate monitor.
module tb_load_store_unit;

   typedef struct packed {
      logic [15:0] data;
      logic [2:0]  rd;
      logic        is_load;
      logic        mis;
   } resp_t;

   typedef struct packed {
      logic [15:0] addr;
      logic [15:0] data;
   } wr_t;

   logic        clk = 1'b0;
   logic        reset;
   logic        req_valid;
   logic        req_ready;
   logic [1:0]  req_op;
   logic [15:0] req_addr;
   logic [15:0] req_wdata;
   logic [2:0]  req_rd;
   logic        resp_valid;
   logic        resp_ready;
   logic [15:0] resp_data;
   logic [2:0]  resp_rd;
   logic        resp_is_load;
   logic        resp_misalign;
   logic        mem_write_enable;
   logic        mem_read_enable;
   logic [15:0] mem_addr;
   logic [15:0] mem_data_in;
   logic [15:0] mem_read_data_out;

   logic [15:0] mem [0:255];
   logic        bd_we;
   logic [7:0]  bd_addr;
   logic [15:0] bd_data;

   resp_t exp_q[$];
   wr_t   wq[$];
   resp_t mon_e;
   wr_t   mon_w;
   int    n_tests = 0;
   int    n_fail  = 0;
   int    m_tests = 0;
   int    m_fail  = 0;

   always #5 clk = ~clk;

   load_store_unit #(.ADDR_W(16), .DATA_W(16), .RD_LAT(1)) dut (
      .clk(clk), .reset(reset),
      .req_valid(req_valid), .req_ready(req_ready), .req_op(req_op),
      .req_addr(req_addr), .req_wdata(req_wdata), .req_rd(req_rd),
      .resp_valid(resp_valid), .resp_ready(resp_ready), .resp_data(resp_data),
      .resp_rd(resp_rd), .resp_is_load(resp_is_load), .resp_misalign(resp_misalign),
      .mem_write_enable(mem_write_enable), .mem_read_enable(mem_read_enable),
      .mem_addr(mem_addr), .mem_data_in(mem_data_in), .mem_read_data_out(mem_read_data_out)
   );

   // data_memory model, one-cycle read latency, plus a bench-side preload port
   always @(posedge clk) begin
      if (bd_we) mem[bd_addr] <= bd_data;
      else if (mem_write_enable) mem[mem_addr[7:0]] <= mem_data_in;
      if (mem_read_enable) mem_read_data_out <= mem[mem_addr[7:0]];
   end

   // Monitor: pops expected responses and writes as the DUT presents them
   always @(negedge clk) begin
      if (!reset) begin
         m_tests++;
         if (mem_read_enable && mem_write_enable) begin
            m_fail++;
            $display("FAIL both_enables: read and write enable both high at %0t", $time);
         end
         if (resp_valid && resp_ready) begin
            m_tests++;
            if (exp_q.size() == 0) begin
               m_fail++;
               $display("FAIL unexpected_resp: data=%h rd=%0d", resp_data, resp_rd);
            end else begin
               mon_e = exp_q.pop_front();
               if ({resp_data, resp_rd, resp_is_load, resp_misalign} !== mon_e) begin
                  m_fail++;
                  $display("FAIL resp: got data=%h rd=%0d load=%b mis=%b, expected data=%h rd=%0d load=%b mis=%b",
                           resp_data, resp_rd, resp_is_load, resp_misalign,
                           mon_e.data, mon_e.rd, mon_e.is_load, mon_e.mis);
               end
            end
         end
         if (mem_write_enable) begin
            m_tests++;
            if (wq.size() == 0) begin
               m_fail++;
               $display("FAIL unexpected_write: addr=%h data=%h", mem_addr, mem_data_in);
            end else begin
               mon_w = wq.pop_front();
               if ({mem_addr, mem_data_in} !== mon_w) begin
                  m_fail++;
                  $display("FAIL mem_write: got addr=%h data=%h, expected addr=%h data=%h",
                           mem_addr, mem_data_in, mon_w.addr, mon_w.data);
               end
            end
         end
      end
   end

   task automatic chk(input string name, input logic [15:0] act, input logic [15:0] exp);
      n_tests++;
      if (act !== exp) begin
         n_fail++;
         $display("FAIL %s: got %h, expected %h", name, act, exp);
      end
   endtask

   task automatic bd_write(input logic [7:0] a, input logic [15:0] d);
      bd_we = 1'b1; bd_addr = a; bd_data = d;
      @(posedge clk); #1;
      bd_we = 1'b0;
   endtask

   task automatic do_op(input logic [1:0] op, input logic [15:0] addr, input logic [15:0] wdata,
                        input logic [2:0] rd, input logic [15:0] exp_data, input logic exp_mis,
                        input int exp_lat, input int hold);
      int   lat;
      int   nre;
      int   nwe;
      logic exp_re1;
      logic exp_we1;
      exp_re1 = (op != 2'b01) && !exp_mis;
      exp_we1 = (op == 2'b01) && !exp_mis;
      exp_q.push_back(resp_t'({exp_data, rd, !op[0], exp_mis}));
      resp_ready = (hold == 0);
      req_op = op; req_addr = addr; req_wdata = wdata; req_rd = rd; req_valid = 1'b1;
      @(posedge clk); #1;
      req_valid = 1'b0;
      lat = 0; nre = 0; nwe = 0;
      @(negedge clk);
      chk("re_at_T1", 16'(mem_read_enable), 16'(exp_re1));
      chk("we_at_T1", 16'(mem_write_enable), 16'(exp_we1));
      if (exp_re1 || exp_we1) chk("addr_at_T1", mem_addr, {1'b0, addr[15:1]});
      for (int k = 1; k <= 20; k++) begin
         if (k > 1) @(negedge clk);
         nre += int'(mem_read_enable);
         nwe += int'(mem_write_enable);
         if (resp_valid) begin
            lat = k;
            break;
         end
      end
      chk("latency", 16'(lat), 16'(exp_lat));
      if (hold > 0) begin
         for (int h = 1; h < hold; h++) begin
            @(negedge clk);
            nre += int'(mem_read_enable);
            nwe += int'(mem_write_enable);
            chk("hold_valid", 16'(resp_valid), 16'd1);
            chk("hold_data", resp_data, exp_data);
            chk("hold_rd", 16'(resp_rd), 16'(rd));
            chk("hold_flags", 16'({resp_is_load, resp_misalign}), 16'({!op[0], exp_mis}));
            chk("hold_req_ready", 16'(req_ready), 16'd0);
         end
         @(posedge clk); #1;
         resp_ready = 1'b1;
         @(negedge clk);
         chk("valid_at_ready_rise", 16'(resp_valid), 16'd1);
      end
      @(posedge clk);
      @(negedge clk);
      chk("valid_dropped", 16'(resp_valid), 16'd0);
      chk("back_to_idle", 16'(req_ready), 16'd1);
      chk("read_pulses", 16'(nre), 16'(exp_re1));
      chk("write_pulses", 16'(nwe), 16'(op[0] && !exp_mis));
   endtask

   initial begin
      reset = 1'b1; req_valid = 1'b0; req_op = 2'b00; req_addr = 16'h0000;
      req_wdata = 16'h0000; req_rd = 3'd0; resp_ready = 1'b1;
      bd_we = 1'b0; bd_addr = 8'd0; bd_data = 16'h0000;
      bd_write(8'd0, 16'h0666);
      bd_write(8'd2, 16'h1234);
      bd_write(8'd3, 16'hA5A5);
      @(negedge clk);
      chk("rst_resp_valid", 16'(resp_valid), 16'd0);
      chk("rst_enables", 16'({mem_read_enable, mem_write_enable}), 16'd0);
      chk("rst_mem_addr", mem_addr, 16'h0000);
      chk("rst_mem_data_in", mem_data_in, 16'h0000);
      chk("rst_resp_data", resp_data, 16'h0000);
      chk("rst_req_ready", 16'(req_ready), 16'd0);
      @(posedge clk); #1;
      reset = 1'b0;
      @(negedge clk);
      chk("ready_after_reset", 16'(req_ready), 16'd1);

      // word load, word store, read-back
      do_op(2'b00, 16'h0000, 16'h0000, 3'd5, 16'h0666, 1'b0, 3, 0);
      wq.push_back(wr_t'({16'h0002, 16'hBEEF}));
      do_op(2'b01, 16'h0004, 16'hBEEF, 3'd1, 16'h0000, 1'b0, 2, 0);
      do_op(2'b00, 16'h0004, 16'h0000, 3'd2, 16'hBEEF, 1'b0, 3, 0);

      // byte store to the high lane, then sign-extended byte loads
      bd_write(8'd2, 16'h1234);
      wq.push_back(wr_t'({16'h0002, 16'h8034}));
      do_op(2'b11, 16'h0005, 16'h0080, 3'd3, 16'h0000, 1'b0, 4, 0);
      do_op(2'b10, 16'h0005, 16'h0000, 3'd4, 16'hFF80, 1'b0, 3, 0);
      do_op(2'b10, 16'h0004, 16'h0000, 3'd6, 16'h0034, 1'b0, 3, 0);

      // misaligned word ops
      do_op(2'b00, 16'h0003, 16'h0000, 3'd7, 16'h0000, 1'b1, 1, 0);
      do_op(2'b01, 16'h0001, 16'h5555, 3'd2, 16'h0000, 1'b1, 1, 0);

      // back-pressured load
      do_op(2'b00, 16'h0000, 16'h0000, 3'd5, 16'h0666, 1'b0, 3, 5);

      // byte store to the low lane keeps the high byte
      wq.push_back(wr_t'({16'h0002, 16'h80FE}));
      do_op(2'b11, 16'h0004, 16'h12FE, 3'd1, 16'h0000, 1'b0, 4, 0);
      do_op(2'b00, 16'h0004, 16'h0000, 3'd3, 16'h80FE, 1'b0, 3, 0);

      // SB aborted by reset while waiting for read data
      req_op = 2'b11; req_addr = 16'h0007; req_wdata = 16'h0011; req_rd = 3'd1; req_valid = 1'b1;
      @(posedge clk); #1;
      req_valid = 1'b0;
      @(posedge clk); #1;
      reset = 1'b1;
      @(posedge clk); #1;
      @(negedge clk);
      chk("abort_we", 16'(mem_write_enable), 16'd0);
      chk("abort_re", 16'(mem_read_enable), 16'd0);
      chk("abort_resp_valid", 16'(resp_valid), 16'd0);
      chk("abort_mem_addr", mem_addr, 16'h0000);
      chk("abort_mem_data_in", mem_data_in, 16'h0000);
      @(posedge clk); #1;
      reset = 1'b0;
      @(negedge clk);
      chk("abort_ready", 16'(req_ready), 16'd1);
      chk("abort_we_after", 16'(mem_write_enable), 16'd0);
      chk("abort_mem_word", mem[3], 16'hA5A5);
      do_op(2'b00, 16'h0006, 16'h0000, 3'd0, 16'hA5A5, 1'b0, 3, 0);

      @(negedge clk);
      chk("resp_queue_empty", 16'(exp_q.size()), 16'd0);
      chk("write_queue_empty", 16'(wq.size()), 16'd0);
      n_tests += m_tests;
      n_fail  += m_fail;
      $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
      $finish;
   end

endmodule

// File: doc/load_store_unit.md
Name: load_store_unit

Overview:
MEM-stage load/store unit of the 16-bit CPU. It sits directly upstream of data_memory and drives that block's write_enable, read_enable, addr and data_in ports, then captures read_data_out. Upstream is the execute stage (valid/ready request); downstream is writeback (valid/ready response). Supports word and byte loads/stores; byte stores are done as read-modify-write on the 16-bit word memory.

Parameters:
ADDR_W, 16, byte-address width of requests and word-address width to data_memory
DATA_W, 16, data width; fixed at 16, byte lanes assume it
RD_LAT, 1, cycles from mem_read_enable high to valid mem_read_data_out; legal values 1..3

Ports:
clk  in  1  system clock, rising edge
reset  in  1  synchronous, active-high reset
req_valid  in  1  request present
req_ready  out  1  unit can accept a request
req_op  in  2  00 LW, 01 SW, 10 LB (sign-extended), 11 SB
req_addr  in  ADDR_W  byte address
req_wdata  in  DATA_W  store data; SB uses [7:0]
req_rd  in  3  destination register tag, echoed on response
resp_valid  out  1  response present
resp_ready  in  1  writeback accepts the response
resp_data  out  DATA_W  load result; 0 for stores and faults
resp_rd  out  3  echoed tag
resp_is_load  out  1  1 for LW/LB
resp_misalign  out  1  LW/SW at an odd address; no memory access was made
mem_write_enable  out  1  to data_memory write_enable
mem_read_enable  out  1  to data_memory read_enable
mem_addr  out  ADDR_W  word address = {1'b0, req_addr[15:1]}
mem_data_in  out  DATA_W  to data_memory data_in
mem_read_data_out  in  DATA_W  from data_memory read_data_out

Behaviour:
- Reset is synchronous, active-high, and checked first in every clocked block. It forces state IDLE and all registered outputs to 0: resp_*, mem_write_enable, mem_read_enable, mem_addr, mem_data_in.
- req_ready = (state==IDLE) && !reset. The request is accepted at the rising edge where req_valid && req_ready; call that edge T. Op, address, wdata and rd are latched at T.
- States: IDLE, ISSUE_RD, WAIT_RD, ISSUE_WR, RESP. All mem_* outputs are registered.
- LW/LB: ISSUE_RD (cycle T+1) holds mem_read_enable=1 for exactly one cycle. WAIT_RD then lasts RD_LAT cycles, and mem_read_data_out is sampled at the final WAIT_RD edge. RESP follows. With RD_LAT=1, resp_valid goes high in cycle T+3.
- SW: ISSUE_WR in cycle T+1 holds mem_write_enable=1 for one cycle with mem_data_in=wdata. RESP is in cycle T+2.
- SB: ISSUE_RD, then WAIT_RD, then ISSUE_WR with the merged word, then RESP; RESP is in cycle T+4 at RD_LAT=1. Byte lane: addr[0]=0 selects [7:0]; addr[0]=1 selects [15:8]. The other byte is preserved from the read word.
- LB: selects the byte by addr[0] and sign-extends it to 16 bits.
- Misaligned LW/SW (addr[0]=1): go straight to RESP in cycle T+1 with resp_misalign=1 and resp_data=0. No mem enable is asserted. LB/SB never fault.
- mem_read_enable and mem_write_enable are never both 1. Both are 0 outside ISSUE_RD and ISSUE_WR.
- mem_addr is stable from ISSUE_RD through ISSUE_WR. mem_data_in is 0 outside ISSUE_WR.
- RESP: resp_valid=1 and all resp_* outputs hold stable until resp_ready. On the edge where resp_valid && resp_ready, the unit returns to IDLE and resp_valid drops the next cycle. There is no same-cycle accept of a new request, so maximum throughput is one op per 3 cycles (SW).
- Stores also produce a response, with resp_is_load=0 and resp_data=0.
- Reset in any state aborts the operation: enables are 0 the cycle after the reset edge. An SB aborted before ISSUE_WR leaves memory unmodified. An in-flight response is discarded.

Test Plan:
1. Reset, memory word 0 = 0x0666; LW addr 0x0000, rd=5 -> mem_read_enable pulses for 1 cycle at T+1 with mem_addr 0x0000; resp_valid at T+3 with resp_data 0x0666, resp_rd 5, resp_is_load 1.
2. SW addr 0x0004, wdata 0xBEEF -> mem_write_enable for one cycle at T+1 with mem_addr 0x0002 and mem_data_in 0xBEEF; resp_valid at T+2 with resp_is_load 0. A following LW 0x0004 returns 0xBEEF.
3. Word 2 = 0x1234; SB addr 0x0005, wdata 0x0080 -> read, then write of 0x8034; LB 0x0005 returns 0xFF80; LB 0x0004 returns 0x0034.
4. LW addr 0x0003 -> resp_misalign 1 and resp_data 0 at T+1; neither enable is ever asserted.
5. LW completes while resp_ready is held low for 5 cycles -> resp_* stable, req_ready 0, no mem enables; resp_valid drops the cycle after resp_ready rises.
6. reset asserted during WAIT_RD of an SB -> mem_write_enable never goes high, outputs are 0 the next cycle, the memory word is unchanged, and req_ready is 1 in the first cycle after reset deasserts.
